elevator_controller: RTL and testbench
======================================

# elevator_controller

Sequential controller driving the elevator simulator's inputs: registers hall/car call requests, owns the current floor and travel direction, and issues one-floor move commands and door-open intervals. It sits upstream of the simulator. The simulator evaluates `cur_floor_out`, `direction_out`, `move_out` and the pending call vectors. The controller applies the same stop rule internally, so it can run stand-alone.

## Interface
- `NUM_FLOORS`, 8: floor count; fixed to match 3-bit floor encoding.
- `TRAVEL_CYCLES`, 3: cycles per one-floor move (≥1).
- `DOOR_CYCLES`, 4: cycles door stays open (≥1).
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `call_in_req`  in  8  car-button pulses, one bit per floor.
- `call_up_req`  in  8  hall-up pulses; bit 7 ignored.
- `call_down_req`  in  8  hall-down pulses; bit 0 ignored.
- `door_hold`  in  1  hold-door request (present only with `ELEVATOR_DOOR_HOLD_EN`).
- `call_in`, `call_up`, `call_down`  out  8 each  registered pending-call vectors.
- `cur_floor_out`  out  3  current floor.
- `direction_out`  out  1  1 = up, 0 = down.
- `move_out`  out  1  high for every cycle of a floor transit.
- `open`  out  1  door open.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Reset values: all pending vectors 0, `cur_floor_out`=0, `direction_out`=1, `move_out`=0, `open`=0, `busy`=0, state IDLE, counters 0.
- **Pending bits**
  - Set on the cycle after a request bit is high. Bits stay set until served.
  - Ignored request bits (`call_up_req[7]`, `call_down_req[0]`) never set.
- **Service predicate at floor f**
  - `call_in[f]`, or
  - `call_up[f]` while `direction_out`=1, or
  - `call_down[f]` while `direction_out`=0, or
  - any pending bit at f with no pending call beyond f in the current direction.
- **"Ahead"**: any pending bit at a floor strictly above f (up) or strictly below f (down).
- **IDLE**
  - If the service predicate holds at f, go to DOOR_OPEN.
  - Else if work is ahead, go to MOVING.
  - Else if work exists in the opposite direction, flip `direction_out` and go to MOVING the next cycle.
  - Else stay in IDLE.
- **MOVING**
  - `move_out`=1 and the travel counter counts up.
  - On reaching `TRAVEL_CYCLES`, `cur_floor_out` steps ±1, then the service predicate is evaluated at the new floor.
  - Predicate true: go to DOOR_OPEN.
  - Predicate false and work ahead: stay in MOVING for the next floor, counter reset.
  - Otherwise: go to IDLE.
- **DOOR_OPEN**
  - `open`=1. On entry, clear `call_in[f]` and the direction-matching hall bit.
  - If no work lies ahead, also clear the opposite hall bit and flip the direction.
  - New requests at f matching the service predicate while open are absorbed: the bit never sets.
  - After `DOOR_CYCLES`, go to IDLE.
- **Boundaries**
  - At floor 7, `direction_out` forced 0 on arrival.
  - At floor 0, `direction_out` forced 1 on arrival.
  - `cur_floor_out` never wraps.
- **Simultaneous events**
  - Clear beats set for the floor being served.
  - Set beats idle for all other floors.
- **Reset mid-operation**: all state returns to reset values immediately. Pending calls are lost.

## Timing
- Request to pending bit: 1 cycle.
- IDLE decision: 1 cycle after pending is visible.
- A one-floor trip from IDLE: `TRAVEL_CYCLES` cycles of `move_out`. `cur_floor_out` updates on the edge ending the last move cycle.
- `open` asserts the cycle after arrival and lasts exactly `DOOR_CYCLES` cycles without hold.
- `move_out` and `open` are never high together.
- All outputs are registered.

## Configuration
- `ELEVATOR_DOOR_HOLD_EN` defined:
  - `door_hold` port exists.
  - While `door_hold`=1 in DOOR_OPEN, the door counter reloads to 0.
  - Door closes `DOOR_CYCLES` cycles after hold deasserts.
- Undefined: no `door_hold` port; the door interval is fixed.

## Test plan
- **Reset mid-move**: `reset_n` low during MOVING → all outputs 0 except `direction_out`=1, the same cycle. No stray `move_out`.
- **Car call two floors up**: floor 0, `call_in_req`=8'h04 one cycle → `call_in`=8'h04 next cycle. `move_out` high 6 cycles (defaults). `cur_floor_out` 1 then 2. `open` 4 cycles. `call_in`=0 on open entry.
- **Hall-down while passing**: going up from 0 with `call_down[3]` and `call_in[5]` pending → no stop at 3. Stop at 5. Direction flips to 0. Then travel to 3 and open. `call_down`=0.
- **Top floor**: `call_up_req`=8'h80, then `call_down_req`=8'h80 → only `call_down[7]` sets. On arrival `direction_out`=0.
- **Absorbed request**: door open at floor 4 going up, `call_in_req`=8'h10 → `call_in` stays 0. `open` length unchanged at 4 cycles.
- **Door hold** (macro on): `door_hold` high 10 cycles during open → `open` lasts 10+4 cycles. Macro off: 4 cycles.

Source files
------------

// File: rtl/elevator_controller.sv
// elevator_controller: registers car/hall calls, owns current floor and travel
// direction, issues one-floor moves and door-open intervals for the simulator.
// Optional feature macro: ELEVATOR_DOOR_HOLD_EN adds the door_hold input, which
// keeps the door open while asserted.
module elevator_controller #(
    parameter int NUM_FLOORS    = 8,
    parameter int TRAVEL_CYCLES = 3,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_FLOORS-1:0]         call_in_req,
    input  logic [NUM_FLOORS-1:0]         call_up_req,
    input  logic [NUM_FLOORS-1:0]         call_down_req,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic                          door_hold,
`endif
    output logic [NUM_FLOORS-1:0]         call_in,
    output logic [NUM_FLOORS-1:0]         call_up,
    output logic [NUM_FLOORS-1:0]         call_down,
    output logic [$clog2(NUM_FLOORS)-1:0] cur_floor_out,
    output logic                          direction_out,
    output logic                          move_out,
    output logic                          open,
    output logic                          busy
);

    localparam int FW = $clog2(NUM_FLOORS);
    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    localparam logic [FW-1:0] TOP_FLOOR   = FW'(NUM_FLOORS - 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

    // Hall-up is meaningless at the top floor, hall-down at the ground floor.
    localparam logic [NUM_FLOORS-1:0] UP_VALID = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_VALID = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [FW-1:0]           floor_q, floor_d;
    logic                    dir_q, dir_d;
    logic [TW-1:0]           travel_cnt_q, travel_cnt_d;
    logic [DW-1:0]           door_cnt_q, door_cnt_d;
    logic [NUM_FLOORS-1:0]   call_in_q, call_in_d;
    logic [NUM_FLOORS-1:0]   call_up_q, call_up_d;
    logic [NUM_FLOORS-1:0]   call_down_q, call_down_d;

    logic [NUM_FLOORS-1:0]   pend_all;
    logic [NUM_FLOORS-1:0]   clr_in, clr_up, clr_dn;
    logic [FW-1:0]           arr_floor;
    logic                    arr_dir;
    logic                    enter_door;
    logic                    hold_active;

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign hold_active = door_hold;
`else
    assign hold_active = 1'b0;
`endif

    // True when any pending call lies strictly beyond floor f in direction dir.
    function automatic logic work_ahead(input logic [NUM_FLOORS-1:0] pend,
                                        input logic [FW-1:0] f,
                                        input logic dir);
        logic [NUM_FLOORS-1:0] ones;
        logic [NUM_FLOORS-1:0] above;
        logic [NUM_FLOORS-1:0] below;
        ones  = '1;
        above = (ones << f) << 1;
        below = ~(ones << f);
        return dir ? |(pend & above) : |(pend & below);
    endfunction

    // Stop rule: car call, direction-matching hall call, or any call here when
    // nothing remains further along the current direction.
    function automatic logic serves(input logic [NUM_FLOORS-1:0] cin,
                                    input logic [NUM_FLOORS-1:0] cup,
                                    input logic [NUM_FLOORS-1:0] cdn,
                                    input logic [FW-1:0] f,
                                    input logic dir);
        logic any_here;
        any_here = cin[f] | cup[f] | cdn[f];
        return cin[f] | (dir & cup[f]) | (~dir & cdn[f]) |
               (any_here & ~work_ahead(cin | cup | cdn, f, dir));
    endfunction

    // State, position and pending-call registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            floor_q      <= '0;
            dir_q        <= 1'b1;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
            call_in_q    <= '0;
            call_up_q    <= '0;
            call_down_q  <= '0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            dir_q        <= dir_d;
            travel_cnt_q <= travel_cnt_d;
            door_cnt_q   <= door_cnt_d;
            call_in_q    <= call_in_d;
            call_up_q    <= call_up_d;
            call_down_q  <= call_down_d;
        end
    end

    // Next-state: dispatch decisions, floor stepping, door timing and call clearing.
    always_comb begin
        state_d      = state_q;
        floor_d      = floor_q;
        dir_d        = dir_q;
        travel_cnt_d = travel_cnt_q;
        door_cnt_d   = door_cnt_q;
        pend_all     = call_in_q | call_up_q | call_down_q;
        clr_in       = '0;
        clr_up       = '0;
        clr_dn       = '0;
        arr_floor    = floor_q;
        arr_dir      = dir_q;
        enter_door   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (serves(call_in_q, call_up_q, call_down_q, floor_q, dir_q)) begin
                    enter_door = 1'b1;
                end else if (work_ahead(pend_all, floor_q, dir_q)) begin
                    state_d      = MOVING;
                    travel_cnt_d = '0;
                end else if (work_ahead(pend_all, floor_q, ~dir_q)) begin
                    dir_d        = ~dir_q;
                    state_d      = MOVING;
                    travel_cnt_d = '0;
                end
            end
            MOVING: begin
                if (travel_cnt_q == TRAVEL_LAST) begin
                    if (dir_q) begin
                        arr_floor = (floor_q != TOP_FLOOR) ? floor_q + 1'b1 : floor_q;
                    end else begin
                        arr_floor = (floor_q != '0) ? floor_q - 1'b1 : floor_q;
                    end
                    if (arr_floor == TOP_FLOOR) begin
                        arr_dir = 1'b0;
                    end else if (arr_floor == '0) begin
                        arr_dir = 1'b1;
                    end else begin
                        arr_dir = dir_q;
                    end
                    floor_d      = arr_floor;
                    dir_d        = arr_dir;
                    travel_cnt_d = '0;
                    if (serves(call_in_q, call_up_q, call_down_q, arr_floor, arr_dir)) begin
                        enter_door = 1'b1;
                    end else if (!work_ahead(pend_all, arr_floor, arr_dir)) begin
                        state_d = IDLE;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + 1'b1;
                end
            end
            DOOR_OPEN: begin
                // Requests here that the stop rule would serve are swallowed.
                clr_in[floor_q] = 1'b1;
                if (dir_q) begin
                    clr_up[floor_q] = 1'b1;
                end else begin
                    clr_dn[floor_q] = 1'b1;
                end
                if (!work_ahead(pend_all, floor_q, dir_q)) begin
                    clr_up[floor_q] = 1'b1;
                    clr_dn[floor_q] = 1'b1;
                end
                if (hold_active) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q == DOOR_LAST) begin
                    state_d    = IDLE;
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Door entry serves the floor; with nothing further ahead the car turns
        // around, except at the end floors where the direction is pinned.
        if (enter_door) begin
            state_d           = DOOR_OPEN;
            door_cnt_d        = '0;
            clr_in[arr_floor] = 1'b1;
            if (arr_dir) begin
                clr_up[arr_floor] = 1'b1;
            end else begin
                clr_dn[arr_floor] = 1'b1;
            end
            if (!work_ahead(pend_all, arr_floor, arr_dir)) begin
                clr_up[arr_floor] = 1'b1;
                clr_dn[arr_floor] = 1'b1;
                dir_d             = ~arr_dir;
            end else begin
                dir_d = arr_dir;
            end
            if (arr_floor == TOP_FLOOR) begin
                dir_d = 1'b0;
            end else if (arr_floor == '0) begin
                dir_d = 1'b1;
            end
        end

        // Clearing the served floor wins over a simultaneous new request.
        call_in_d   = (call_in_q   | call_in_req)              & ~clr_in;
        call_up_d   = (call_up_q   | (call_up_req & UP_VALID))   & ~clr_up;
        call_down_d = (call_down_q | (call_down_req & DN_VALID)) & ~clr_dn;
    end

    assign call_in       = call_in_q;
    assign call_up       = call_up_q;
    assign call_down     = call_down_q;
    assign cur_floor_out = floor_q;
    assign direction_out = dir_q;
    assign move_out      = (state_q == MOVING);
    assign open          = (state_q == DOOR_OPEN);
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_controller.sv
// tb_elevator_controller: directed scenarios plus randomized traffic checked
// against a floor-level behavioural model of the elevator.
module tb_elevator_controller;

    localparam int TRAVEL = 3;
    localparam int DOOR   = 4;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] call_in_req = '0;
    logic [7:0] call_up_req = '0;
    logic [7:0] call_down_req = '0;
`ifdef ELEVATOR_DOOR_HOLD_EN
    logic       door_hold = 1'b0;
`endif
    logic [7:0] call_in, call_up, call_down;
    logic [2:0] cur_floor_out;
    logic       direction_out, move_out, open, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit [7:0] m_in, m_up, m_dn;
    bit [7:0] k_in, k_up, k_dn;
    int       m_floor;
    bit       m_dir;
    int       m_mode;
    int       m_t;

    elevator_controller #(
        .NUM_FLOORS(8), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .call_in_req(call_in_req),
        .call_up_req(call_up_req),
        .call_down_req(call_down_req),
`ifdef ELEVATOR_DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .call_in(call_in),
        .call_up(call_up),
        .call_down(call_down),
        .cur_floor_out(cur_floor_out),
        .direction_out(direction_out),
        .move_out(move_out),
        .open(open),
        .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic bit m_work(int f, bit d);
        for (int g = 0; g < 8; g++) begin
            if ((d ? (g > f) : (g < f)) && (m_in[g] || m_up[g] || m_dn[g])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_serves(int f, bit d);
        if (m_in[f]) return 1'b1;
        if (d && m_up[f]) return 1'b1;
        if (!d && m_dn[f]) return 1'b1;
        return (m_in[f] || m_up[f] || m_dn[f]) && !m_work(f, d);
    endfunction

    function automatic logic [30:0] model_vec();
        return {m_in, m_up, m_dn, 3'(m_floor), m_dir,
                m_mode == M_MOVE, m_mode == M_DOOR, m_mode != M_IDLE};
    endfunction

    function automatic logic [30:0] dut_vec();
        return {call_in, call_up, call_down, cur_floor_out, direction_out, move_out, open, busy};
    endfunction

    task automatic model_reset();
        m_in = 0; m_up = 0; m_dn = 0;
        m_floor = 0; m_dir = 1'b1; m_mode = M_IDLE; m_t = 0;
    endtask

    task automatic model_open(int f);
        m_mode = M_DOOR;
        m_t    = 0;
        k_in[f] = 1'b1;
        if (m_dir) k_up[f] = 1'b1; else k_dn[f] = 1'b1;
        if (!m_work(f, m_dir)) begin
            k_up[f] = 1'b1;
            k_dn[f] = 1'b1;
            m_dir   = !m_dir;
        end
        if (f == 7) m_dir = 1'b0;
        if (f == 0) m_dir = 1'b1;
    endtask

    // One clock of the model, using the requests presented during that cycle.
    task automatic model_step();
        bit [7:0] rin, rup, rdn;
        int f;
        rin = call_in_req;
        rup = call_up_req & 8'h7F;
        rdn = call_down_req & 8'hFE;
        k_in = 0; k_up = 0; k_dn = 0;
        f = m_floor;
        if (m_mode == M_IDLE) begin
            if (m_serves(f, m_dir)) model_open(f);
            else if (m_work(f, m_dir)) begin m_mode = M_MOVE; m_t = 0; end
            else if (m_work(f, !m_dir)) begin m_dir = !m_dir; m_mode = M_MOVE; m_t = 0; end
        end else if (m_mode == M_MOVE) begin
            m_t++;
            if (m_t == TRAVEL) begin
                m_t = 0;
                f = m_dir ? f + 1 : f - 1;
                if (f > 7) f = 7;
                if (f < 0) f = 0;
                m_floor = f;
                if (f == 7) m_dir = 1'b0;
                if (f == 0) m_dir = 1'b1;
                if (m_serves(f, m_dir)) model_open(f);
                else if (!m_work(f, m_dir)) m_mode = M_IDLE;
            end
        end else begin
            k_in[f] = 1'b1;
            if (m_dir) k_up[f] = 1'b1; else k_dn[f] = 1'b1;
            if (!m_work(f, m_dir)) begin k_up[f] = 1'b1; k_dn[f] = 1'b1; end
            m_t++;
            if (m_t == DOOR) begin m_mode = M_IDLE; m_t = 0; end
        end
        m_in = (m_in | rin) & ~k_in;
        m_up = (m_up | rup) & ~k_up;
        m_dn = (m_dn | rdn) & ~k_dn;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        call_in_req = '0; call_up_req = '0; call_down_req = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Advances until open reaches lvl; ok=0 if the cycle budget runs out.
    task automatic wait_open(input bit lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (open === lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec() !== {24'h0, 3'd0, 1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), {24'h0, 3'd0, 1'b1, 3'b000});
        end
    endtask

    task automatic test_car_call();
        int  move_cnt = 0, open_cnt = 0, seq = 0;
        bit  was_open = 0;
        logic [2:0] last_floor;
        do_reset();
        call_in_req = 8'h04;
        tick();
        call_in_req = 8'h00;
        n_checks++;
        if (call_in !== 8'h04) begin
            n_fail++; $display("FAIL car_call_pending: got %h expected 04", call_in);
        end
        last_floor = cur_floor_out;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL car_call_model: got %h expected %h", dut_vec(), model_vec());
            end
            if (move_out) move_cnt++;
            if (cur_floor_out !== last_floor) begin seq = seq * 10 + int'(cur_floor_out); last_floor = cur_floor_out; end
            if (open && !was_open) begin
                n_checks++;
                if (call_in !== 8'h00) begin
                    n_fail++; $display("FAIL car_call_clear: got %h expected 00", call_in);
                end
            end
            if (open) open_cnt++;
            if (was_open && !open) break;
            was_open = open;
        end
        n_checks++;
        if (move_cnt != 6) begin n_fail++; $display("FAIL car_call_move_len: got %0d expected 6", move_cnt); end
        n_checks++;
        if (seq != 12) begin n_fail++; $display("FAIL car_call_floors: got %0d expected 12", seq); end
        n_checks++;
        if (open_cnt != 4) begin n_fail++; $display("FAIL car_call_open_len: got %0d expected 4", open_cnt); end
    endtask

    task automatic test_hall_passing();
        bit ok;
        do_reset();
        call_down_req = 8'h08;
        call_in_req   = 8'h20;
        tick();
        call_down_req = 8'h00;
        call_in_req   = 8'h00;
        wait_open(1'b1, 60, ok);
        n_checks++;
        if (!ok || cur_floor_out !== 3'd5) begin
            n_fail++; $display("FAIL hall_first_stop: got floor %0d ok=%0d expected 5", cur_floor_out, ok);
        end
        n_checks++;
        if (direction_out !== 1'b0 || call_in !== 8'h00) begin
            n_fail++; $display("FAIL hall_flip: got dir %0d call_in %h expected 0 00", direction_out, call_in);
        end
        wait_open(1'b0, 20, ok);
        wait_open(1'b1, 40, ok);
        n_checks++;
        if (!ok || cur_floor_out !== 3'd3) begin
            n_fail++; $display("FAIL hall_second_stop: got floor %0d ok=%0d expected 3", cur_floor_out, ok);
        end
        n_checks++;
        if (call_down !== 8'h00) begin
            n_fail++; $display("FAIL hall_down_clear: got %h expected 00", call_down);
        end
    endtask

    task automatic test_top_floor();
        bit ok;
        do_reset();
        call_up_req = 8'h80;
        tick();
        call_up_req = 8'h00;
        n_checks++;
        if (call_up !== 8'h00) begin n_fail++; $display("FAIL top_up_ignored: got %h expected 00", call_up); end
        call_down_req = 8'h80;
        tick();
        call_down_req = 8'h00;
        n_checks++;
        if (call_down !== 8'h80) begin n_fail++; $display("FAIL top_down_set: got %h expected 80", call_down); end
        wait_open(1'b1, 60, ok);
        n_checks++;
        if (!ok || cur_floor_out !== 3'd7 || direction_out !== 1'b0) begin
            n_fail++; $display("FAIL top_arrival: got floor %0d dir %0d ok=%0d expected 7 0", cur_floor_out, direction_out, ok);
        end
    endtask

    task automatic test_absorb();
        bit ok;
        int open_len = 1;
        do_reset();
        call_in_req = 8'h50;
        tick();
        call_in_req = 8'h00;
        wait_open(1'b1, 60, ok);
        n_checks++;
        if (!ok || cur_floor_out !== 3'd4 || direction_out !== 1'b1) begin
            n_fail++; $display("FAIL absorb_stop: got floor %0d dir %0d ok=%0d expected 4 1", cur_floor_out, direction_out, ok);
        end
        call_in_req = 8'h10;
        tick();
        call_in_req = 8'h00;
        n_checks++;
        if (call_in !== 8'h40) begin n_fail++; $display("FAIL absorb_pending: got %h expected 40", call_in); end
        for (int i = 0; i < 20 && open; i++) begin
            open_len++;
            tick();
        end
        n_checks++;
        if (open_len != 4) begin n_fail++; $display("FAIL absorb_open_len: got %0d expected 4", open_len); end
    endtask

    task automatic test_reset_mid_move();
        bit ok = 0;
        do_reset();
        call_in_req = 8'h80;
        tick();
        call_in_req = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (move_out) begin ok = 1; break; end
        end
        tick();
        n_checks++;
        if (!ok || move_out !== 1'b1) begin n_fail++; $display("FAIL mid_move_start: got move %0d expected 1", move_out); end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== {24'h0, 3'd0, 1'b1, 3'b000}) begin
            n_fail++; $display("FAIL mid_move_reset: got %h expected %h", dut_vec(), {24'h0, 3'd0, 1'b1, 3'b000});
        end
        model_reset();
        tick();
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== model_vec() || move_out !== 1'b0) begin
                n_fail++; $display("FAIL mid_move_after: got %h expected %h", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_door_interval();
        bit ok;
        int open_len = 0;
        do_reset();
        call_in_req = 8'h02;
        tick();
        call_in_req = 8'h00;
        wait_open(1'b1, 30, ok);
`ifdef ELEVATOR_DOOR_HOLD_EN
        door_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (open) open_len++;
            tick();
        end
        door_hold = 1'b0;
`endif
        for (int i = 0; i < 30 && open; i++) begin
            open_len++;
            tick();
        end
        n_checks++;
`ifdef ELEVATOR_DOOR_HOLD_EN
        if (!ok || open_len != 14) begin n_fail++; $display("FAIL door_hold_len: got %0d expected 14", open_len); end
`else
        if (!ok || open_len != 4) begin n_fail++; $display("FAIL door_len: got %0d expected 4", open_len); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            call_in_req   = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            call_up_req   = ($urandom_range(0, 14) == 0) ? 8'($urandom) : 8'h00;
            call_down_req = ($urandom_range(0, 14) == 0) ? 8'($urandom) : 8'h00;
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL random_model cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            n_checks++;
            if (move_out && open) begin
                n_fail++; $display("FAIL random_move_open cycle %0d: got move=1 open=1 expected exclusive", i);
            end
        end
        call_in_req = '0; call_up_req = '0; call_down_req = '0;
    endtask

    initial begin
        test_reset();
        test_car_call();
        test_hall_passing();
        test_top_floor();
        test_absorb();
        test_reset_mid_move();
        test_door_interval();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
